// File: rtl/regfile_sp_if.sv
// Decode-stage register file / stack-pointer bus: read ports, register write,
// SP ops, interrupt shadow control and sticky error flags.
interface regfile_sp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [DATA_W-1:0]        wdata;
  logic [1:0]               sp_op;
  logic [DATA_W-1:0]        sp_wdata;
  logic [DATA_W-1:0]        sp_out;
  logic [DATA_W-1:0]        sp_cur;
  logic                     int_enter;
  logic                     int_exit;
  logic                     in_isr;
  logic                     err_clr;
  logic                     sp_ovf;
  logic                     sp_unf;
  logic                     nest_err;

  modport master (
    output rd_addr, we, waddr, wdata, sp_op, sp_wdata, int_enter, int_exit, err_clr,
    input  rd_data, sp_out, sp_cur, in_isr, sp_ovf, sp_unf, nest_err
  );

  modport slave (
    input  rd_addr, we, waddr, wdata, sp_op, sp_wdata, int_enter, int_exit, err_clr,
    output rd_data, sp_out, sp_cur, in_isr, sp_ovf, sp_unf, nest_err
  );
endinterface

// File: rtl/regfile_sp_unit.sv
// Parametrised register file with per-port write-through bypass, plus a
// limit-checked hardware stack pointer with single-level interrupt shadowing.
module regfile_sp_rdport #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] data_o
);
  assign data_o = (we_i && (waddr_i == addr_i)) ? wdata_i : stored_i;
endmodule

module regfile_sp_unit #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_REGS   = 32,
  parameter int                NUM_RD     = 2,
  parameter logic [DATA_W-1:0] SP_RESET   = 32'h0000_3000,
  parameter logic [DATA_W-1:0] SP_LIMIT   = 32'h0000_2000,
  parameter int                WORD_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  regfile_sp_if.slave     bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [DATA_W:0] STEP = (DATA_W+1)'(WORD_BYTES);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] sp_q, sp_d, shadow_q, shadow_d;
  logic              in_isr_q, in_isr_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, nest_q, nest_d;

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (bus.we) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] stored;
    assign addr   = bus.rd_addr[k*AW +: AW];
    assign stored = regs_q[addr];
    regfile_sp_rdport #(.DATA_W(DATA_W), .AW(AW)) u_port (
      .addr_i   (addr),
      .stored_i (stored),
      .we_i     (bus.we),
      .waddr_i  (bus.waddr),
      .wdata_i  (bus.wdata),
      .data_o   (bus.rd_data[k*DATA_W +: DATA_W])
    );
  end

  // ---------------- stack pointer ----------------
  // Widened by one bit so a wrapping step can never look in range.
  logic [DATA_W:0]   dec_w, inc_w;
  logic              push_ok, pop_ok;
  logic              enter_v, exit_v, nest_set, ovf_set, unf_set;
  logic [DATA_W-1:0] sp_out_c, sp_op_nx;

  assign dec_w   = {1'b0, sp_q} - STEP;
  assign inc_w   = {1'b0, sp_q} + STEP;
  assign push_ok = {1'b0, sp_q} >= ({1'b0, SP_LIMIT} + STEP);
  assign pop_ok  = inc_w <= {1'b0, SP_RESET};

  // Simultaneous enter+exit cancel each other and the op proceeds.
  assign enter_v  = bus.int_enter && !bus.int_exit && !in_isr_q;
  assign nest_set = bus.int_enter && !bus.int_exit &&  in_isr_q;
  assign exit_v   = bus.int_exit  && !bus.int_enter &&  in_isr_q;

  always_comb begin
    sp_out_c = sp_q;
    sp_op_nx = sp_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    unique case (bus.sp_op)
      2'b01: if (push_ok) begin
               sp_out_c = dec_w[DATA_W-1:0];
               sp_op_nx = dec_w[DATA_W-1:0];
             end else begin
               ovf_set  = !exit_v;
             end
      2'b10: if (pop_ok) sp_op_nx = inc_w[DATA_W-1:0];
             else        unf_set  = !exit_v;
      2'b11: begin
               sp_out_c = bus.sp_wdata;
               sp_op_nx = bus.sp_wdata;
             end
      default: ;
    endcase

    // Interrupt return restores the shadow and discards this cycle's op result.
    sp_d     = exit_v  ? shadow_q : sp_op_nx;
    shadow_d = enter_v ? sp_op_nx : shadow_q;
    in_isr_d = enter_v ? 1'b1 : (exit_v ? 1'b0 : in_isr_q);

    ovf_d  = ovf_set  || (ovf_q  && !bus.err_clr);
    unf_d  = unf_set  || (unf_q  && !bus.err_clr);
    nest_d = nest_set || (nest_q && !bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q     <= SP_RESET;
      shadow_q <= SP_RESET;
      in_isr_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      nest_q   <= 1'b0;
    end else begin
      sp_q     <= sp_d;
      shadow_q <= shadow_d;
      in_isr_q <= in_isr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      nest_q   <= nest_d;
    end
  end

  assign bus.sp_out   = sp_out_c;
  assign bus.sp_cur   = sp_q;
  assign bus.in_isr   = in_isr_q;
  assign bus.sp_ovf   = ovf_q;
  assign bus.sp_unf   = unf_q;
  assign bus.nest_err = nest_q;
endmodule

// File: tb/tb_regfile_sp_unit.sv
// Directed bench for regfile_sp_unit: integer-arithmetic reference model checked
// every cycle, plus literal expectations taken from hand-worked sequences.
module tb_regfile_sp_unit;
  localparam int DATA_W = 32, NUM_REGS = 32, NUM_RD = 2, AW = 5;
  localparam longint RST_SP = 64'h3000, LIM_SP = 64'h2000, WB = 4;

  logic clk, rst_n;
  int   checks, failures;

  regfile_sp_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) bus ();

  regfile_sp_unit #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint     m_sp, m_shadow, n_sp;
  bit         m_isr, m_ovf, m_unf, m_nest, m_en, m_ex, m_ret;
  logic [31:0] m_regs [NUM_REGS];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sp = RST_SP; m_shadow = RST_SP;
      m_isr = 0; m_ovf = 0; m_unf = 0; m_nest = 0;
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 0;
    end else begin
      if (bus.err_clr) begin m_ovf = 0; m_unf = 0; m_nest = 0; end
      m_en  = bus.int_enter && !bus.int_exit;
      m_ex  = bus.int_exit && !bus.int_enter;
      m_ret = m_ex && m_isr;
      n_sp  = m_sp;
      if (bus.sp_op == 2'b01) begin
        if (m_sp - WB < LIM_SP) m_ovf = m_ovf || !m_ret; else n_sp = m_sp - WB;
      end else if (bus.sp_op == 2'b10) begin
        if (m_sp + WB > RST_SP) m_unf = m_unf || !m_ret; else n_sp = m_sp + WB;
      end else if (bus.sp_op == 2'b11) begin
        n_sp = longint'(bus.sp_wdata);
      end
      if (m_en && m_isr) m_nest = 1;
      else if (m_en) begin m_shadow = n_sp; m_isr = 1; end
      else if (m_ret) begin n_sp = m_shadow; m_isr = 0; end
      m_sp = n_sp;
      if (bus.we) m_regs[bus.waddr] = bus.wdata;
    end
  end

  function automatic longint exp_sp_out();
    if (bus.sp_op == 2'b01 && !(m_sp - WB < LIM_SP)) return m_sp - WB;
    if (bus.sp_op == 2'b11) return longint'(bus.sp_wdata);
    return m_sp;
  endfunction

  always @(negedge clk) begin
    logic [AW-1:0] a;
    logic [31:0]   e;
    for (int k = 0; k < NUM_RD; k++) begin
      a = bus.rd_addr[k*AW +: AW];
      e = (bus.we && bus.waddr == a) ? bus.wdata : m_regs[a];
      chk($sformatf("model_rd%0d", k), bus.rd_data[k*DATA_W +: DATA_W], e);
    end
    chk("model_sp_out", bus.sp_out, exp_sp_out());
    chk("model_sp_cur", bus.sp_cur, m_sp);
    chk("model_flags", {bus.in_isr, bus.sp_ovf, bus.sp_unf, bus.nest_err},
        {m_isr, m_ovf, m_unf, m_nest});
  end

  // ---------------- stimulus ----------------
  function automatic logic [2*AW-1:0] pk(input int a0, input int a1);
    logic [AW-1:0] x0, x1;
    x0 = a0[AW-1:0];
    x1 = a1[AW-1:0];
    return {x1, x0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic [1:0] o, input logic [31:0] wd);
    bus.sp_op = o;
    bus.sp_wdata = wd;
  endtask

  logic [31:0] exp_push [3];
  logic [31:0] exp_pop  [3];

  initial begin
    checks = 0; failures = 0;
    exp_push[0] = 32'h2FFC; exp_push[1] = 32'h2FF8; exp_push[2] = 32'h2FF4;
    exp_pop[0]  = 32'h2FF4; exp_pop[1]  = 32'h2FF8; exp_pop[2]  = 32'h2FFC;
    rst_n = 1'b0;
    bus.rd_addr = pk(5, 5); bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    setop(2'b00, 0); bus.int_enter = 0; bus.int_exit = 0; bus.err_clr = 0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_sp_cur", bus.sp_cur, 32'h3000);
    chk("rst_flags", {bus.in_isr, bus.sp_ovf, bus.sp_unf, bus.nest_err}, 4'b0);
    chk("rst_rd", bus.rd_data, 64'h0);

    // write-through bypass then stored value
    bus.we = 1; bus.waddr = 5; bus.wdata = 32'hDEADBEEF;
    #1 chk("bypass_rd", bus.rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
    tick(); bus.we = 0;
    #1 chk("stored_rd", bus.rd_data, {32'hDEADBEEF, 32'hDEADBEEF});

    // fill every register, including 0
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.we = 1; bus.waddr = AW'(i); bus.wdata = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      bus.rd_addr = pk(i, (i + 31) % NUM_REGS);
      tick();
    end
    bus.we = 0; bus.rd_addr = pk(0, 31);
    #1 chk("reg0_writable", bus.rd_data[31:0], 32'hA5A5_0000);

    // push x3 with concurrent register writes, then pop x3
    for (int i = 0; i < 3; i++) begin
      setop(2'b01, 0); bus.we = 1; bus.waddr = AW'(10 + i); bus.wdata = 32'h100 + i;
      bus.rd_addr = pk(10 + i, 9 + i);
      #1 chk($sformatf("push%0d_sp_out", i), bus.sp_out, exp_push[i]);
      tick();
    end
    bus.we = 0;
    chk("push3_sp_cur", bus.sp_cur, 32'h2FF4);
    for (int i = 0; i < 3; i++) begin
      setop(2'b10, 0);
      #1 chk($sformatf("pop%0d_sp_out", i), bus.sp_out, exp_pop[i]);
      tick();
    end
    setop(2'b00, 0);
    chk("pop3_sp_cur", bus.sp_cur, 32'h3000);

    // underflow, load bypass, overflow, clear
    setop(2'b10, 0); tick(); setop(2'b00, 0);
    chk("unf_sp_cur", bus.sp_cur, 32'h3000);
    chk("unf_flag", bus.sp_unf, 1'b1);
    setop(2'b11, 32'h2004);
    #1 chk("load_bypass", bus.sp_out, 32'h2004);
    tick(); setop(2'b01, 0); tick();
    chk("push_to_limit", bus.sp_cur, 32'h2000);
    chk("push_to_limit_ovf", bus.sp_ovf, 1'b0);
    tick(); setop(2'b00, 0);
    chk("ovf_sp_cur", bus.sp_cur, 32'h2000);
    chk("ovf_flag", bus.sp_ovf, 1'b1);
    bus.err_clr = 1; tick(); bus.err_clr = 0;
    chk("clr_flags", {bus.sp_ovf, bus.sp_unf, bus.nest_err}, 3'b0);

    // wrap boundaries
    setop(2'b11, 32'h0); tick(); setop(2'b01, 0); tick();
    chk("wrap_push", {bus.sp_cur, bus.sp_ovf}, {32'h0, 1'b1});
    setop(2'b11, 32'hFFFF_FFFC); tick(); setop(2'b10, 0); tick();
    chk("wrap_pop", {bus.sp_cur, bus.sp_unf}, {32'hFFFF_FFFC, 1'b1});
    bus.err_clr = 1; setop(2'b00, 0); tick(); bus.err_clr = 0;

    // interrupt shadowing
    setop(2'b11, 32'h2FF0); tick();
    setop(2'b01, 0); bus.int_enter = 1; tick(); bus.int_enter = 0;
    chk("enter_isr", {bus.in_isr, bus.sp_cur}, {1'b1, 32'h2FEC});
    tick(); tick();
    chk("isr_push2", bus.sp_cur, 32'h2FE4);
    setop(2'b10, 0); bus.int_exit = 1;
    #1 chk("exit_sp_out", bus.sp_out, 32'h2FE4);
    tick(); bus.int_exit = 0; setop(2'b00, 0);
    chk("exit_restore", {bus.in_isr, bus.sp_cur}, {1'b0, 32'h2FEC});

    // nesting: second enter ignored, flag wins over same-cycle clear
    bus.int_enter = 1; tick();
    setop(2'b11, 32'h2F00); bus.err_clr = 1; tick();
    bus.err_clr = 0; bus.int_enter = 0; setop(2'b00, 0);
    chk("nest_err", {bus.nest_err, bus.sp_cur}, {1'b1, 32'h2F00});
    bus.int_exit = 1; tick(); bus.int_exit = 0;
    chk("nest_shadow", {bus.in_isr, bus.sp_cur}, {1'b0, 32'h2FEC});
    bus.int_enter = 1; bus.int_exit = 1; setop(2'b01, 0); tick();
    chk("both_out_isr", {bus.in_isr, bus.sp_cur}, {1'b0, 32'h2FE8});
    bus.int_exit = 0; setop(2'b00, 0); tick();
    bus.int_exit = 1; tick();
    chk("both_in_isr", bus.in_isr, 1'b1);
    bus.int_enter = 0; tick(); bus.int_exit = 0;
    chk("final_exit", bus.in_isr, 1'b0);
    bus.int_exit = 1; tick(); bus.int_exit = 0;
    chk("exit_idle_ignored", {bus.in_isr, bus.sp_cur}, {1'b0, 32'h2FE8});

    // asynchronous reset mid-push sequence with flags set
    setop(2'b11, 32'h0); tick(); setop(2'b01, 0); tick(); tick();
    bus.rd_addr = pk(5, 10);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sp_cur", bus.sp_cur, 32'h3000);
    chk("arst_flags", {bus.in_isr, bus.sp_ovf, bus.sp_unf, bus.nest_err}, 4'b0);
    chk("arst_regs", bus.rd_data, 64'h0);
    setop(2'b00, 0);
    #2 rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_sp", bus.sp_cur, 32'h3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
